// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges scalar-pipe and vector-pipe writebacks onto one scalar-RF
// and one vector-RF write port, absorbing same-cycle conflicts in per-port FIFOs.

module wb_arb_port #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         a_vld_i,
  input  logic [W-1:0] a_dat_i,
  input  logic         b_vld_i,
  input  logic [W-1:0] b_dat_i,
  output logic         we_o,
  output logic [W-1:0] dat_o,
  output logic         stall_o,
  output logic         drop_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, wr1_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   free_slots;
  logic          pop, push_a, push_b, acc_a, acc_b, iss;
  logic          wr0_en, wr1_en;
  logic [W-1:0]  iss_dat, wr0_dat;
  logic          we_q, we_d;
  logic [W-1:0]  dat_q, dat_d;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    pop    = (cnt_q != '0);
    // Head has priority; the first valid incoming request only issues when the FIFO is empty.
    push_a = pop & a_vld_i;
    push_b = b_vld_i & (pop | a_vld_i);
    iss    = pop | a_vld_i | b_vld_i;
    if (pop)          iss_dat = mem_q[rptr_q];
    else if (a_vld_i) iss_dat = a_dat_i;
    else if (b_vld_i) iss_dat = b_dat_i;
    else              iss_dat = '0;

    // Space counts the slot freed by this cycle's pop, so full+pop+push is legal.
    free_slots = (CW+1)'(DEPTH) - {1'b0, cnt_q} + {{CW{1'b0}}, pop};
    acc_a      = push_a & (free_slots != '0);
    acc_b      = push_b & (free_slots > {{CW{1'b0}}, acc_a});
    drop_o     = (push_a & ~acc_a) | (push_b & ~acc_b);

    wr0_en  = acc_a | acc_b;
    wr0_dat = acc_a ? a_dat_i : b_dat_i;
    wr1_en  = acc_a & acc_b;
    wr1_idx = inc(wptr_q);

    if (wr1_en)      wptr_d = inc(inc(wptr_q));
    else if (wr0_en) wptr_d = inc(wptr_q);
    else             wptr_d = wptr_q;
    rptr_d = pop ? inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(acc_a) + CW'(acc_b) - CW'(pop);

    we_d  = iss;
    dat_d = iss ? iss_dat : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      we_q   <= 1'b0;
      dat_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      we_q   <= we_d;
      dat_q  <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr0_en) mem_q[wptr_q]  <= wr0_dat;
    if (wr1_en) mem_q[wr1_idx] <= b_dat_i;
  end

  assign we_o    = we_q;
  assign dat_o   = dat_q;
  assign stall_o = (cnt_q > CW'(DEPTH - 2));
endmodule

module wb_arbiter #(
  parameter int DATA_W  = 36,
  parameter int VDATA_W = 128,
  parameter int LANES   = 4,
  parameter int ADDR_W  = 5,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_we,
  input  logic [ADDR_W-1:0]  s_waddr,
  input  logic [DATA_W-1:0]  s_wdata,
  input  logic               s_vwe,
  input  logic [ADDR_W-1:0]  s_vwaddr,
  input  logic [VDATA_W-1:0] s_vwdata,
  input  logic [LANES-1:0]   s_vmask,
  input  logic               v_we,
  input  logic [ADDR_W-1:0]  v_waddr,
  input  logic [DATA_W-1:0]  v_wdata,
  input  logic               v_vwe,
  input  logic [ADDR_W-1:0]  v_vwaddr,
  input  logic [VDATA_W-1:0] v_vwdata,
  input  logic [LANES-1:0]   v_vmask,
  output logic               rf_we,
  output logic [ADDR_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               vrf_we,
  output logic [ADDR_W-1:0]  vrf_waddr,
  output logic [VDATA_W-1:0] vrf_wdata,
  output logic [LANES-1:0]   vrf_wmask,
  output logic               wb_stall,
  output logic               wb_overflow
);
  localparam int SW = ADDR_W + DATA_W;
  localparam int VW = ADDR_W + VDATA_W + LANES;

  logic [SW-1:0] s_out;
  logic [VW-1:0] v_out;
  logic          s_stall, v_stall, s_drop, v_drop;
  logic          ovf_q, ovf_d;

  wb_arb_port #(.W(SW), .DEPTH(DEPTH)) u_sport (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .a_vld_i (s_we),
    .a_dat_i ({s_waddr, s_wdata}),
    .b_vld_i (v_we),
    .b_dat_i ({v_waddr, v_wdata}),
    .we_o    (rf_we),
    .dat_o   (s_out),
    .stall_o (s_stall),
    .drop_o  (s_drop)
  );

  wb_arb_port #(.W(VW), .DEPTH(DEPTH)) u_vport (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .a_vld_i (s_vwe),
    .a_dat_i ({s_vwaddr, s_vwdata, s_vmask}),
    .b_vld_i (v_vwe),
    .b_dat_i ({v_vwaddr, v_vwdata, v_vmask}),
    .we_o    (vrf_we),
    .dat_o   (v_out),
    .stall_o (v_stall),
    .drop_o  (v_drop)
  );

  assign {rf_waddr, rf_wdata}              = s_out;
  assign {vrf_waddr, vrf_wdata, vrf_wmask} = v_out;
  assign wb_stall                          = s_stall | v_stall;

  always_comb ovf_d = ovf_q | s_drop | v_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign wb_overflow = ovf_q;
endmodule
